// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular FIFO that carries {pc, inst} from fetch to decode.
// The head entry is shown one cycle after it is written, and there is no same-cycle bypass.
module inst_fetch_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = XLEN + 32;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq, deq;
    logic [EW-1:0] head_entry;

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign enq = in_valid  && in_ready;
    assign deq = out_valid && out_ready;

    assign head_entry = mem_q[head_q];
    assign out_pc     = out_valid ? head_entry[EW-1:32] : '0;
    assign out_inst   = out_valid ? head_entry[31:0]    : '0;

    // Next-state for the pointers and occupancy; the power-of-two depth makes the pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + AW'(1);
        end
        if (deq) begin
            head_d = head_q + AW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; a write that lands in a flush or reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset && !flush && enq) begin
            mem_q[tail_q] <= {in_pc, in_inst};
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of the program counter field.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0), sampled on the rising edge of clk.
REQ-005 SHALL have port flush  input  1  discards all queued entries (branch mispredict / redirect).
REQ-006 SHALL have port in_valid  input  1  fetch stage presents an entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port in_pc  input  XLEN  PC of the incoming instruction.
REQ-009 SHALL have port in_inst  input  32  incoming instruction word.
REQ-010 SHALL have port out_valid  output  1  head entry is available to decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-012 SHALL have port out_pc  output  XLEN  PC of the head entry.
REQ-013 SHALL have port out_inst  output  32  instruction word of the head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-015 SHALL be a circular FIFO with a head pointer, a tail pointer and an occupancy counter, all registered.
REQ-016 SHALL perform an enqueue when in_valid=1 and in_ready=1 at a rising edge: write {in_pc, in_inst} at tail, then advance tail.
REQ-017 SHALL perform a dequeue when out_valid=1 and out_ready=1 at a rising edge: advance head.
REQ-018 SHALL drive in_ready = (count < DEPTH), a function of registered state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (count != 0), a function of registered state only.
REQ-020 SHALL drive out_pc/out_inst from the head entry when out_valid=1, and drive them to all zeros when out_valid=0.
REQ-021 SHALL have a minimum latency of one cycle: an entry enqueued at edge N is visible on out_* after edge N; there is no same-cycle bypass.
REQ-022 SHALL, on a simultaneous enqueue and dequeue, leave count unchanged and move both pointers; this is legal when count is 0 < count < DEPTH.
REQ-023 SHALL, when full (count=DEPTH), hold in_ready=0 even if out_ready=1, so no enqueue occurs that cycle.
REQ-024 SHALL, when empty, perform no dequeue regardless of out_ready.
REQ-025 SHALL wrap the head and tail pointers modulo DEPTH, with no corruption across the wrap.
REQ-026 SHALL, on flush=1 at an edge, set count=0 and head=tail=0, ignoring any enqueue or dequeue in the same cycle.
REQ-027 SHALL not depend on in_valid for in_ready.
REQ-028 SHALL preserve the order of entries exactly, with no duplication or loss outside flush/reset.
REQ-029 SHALL keep storage entries unreset; only the pointers and count are reset.

Reset
REQ-030 SHALL, while reset=0 at an edge, set count=0 and head=tail=0; reset has priority over flush, enqueue and dequeue.
REQ-031 SHALL drive these output values during and after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=0.
REQ-032 SHALL discard all contents when reset is asserted mid-stream; no stale entry reappears after release.

Verification
REQ-033 SHALL pass: single enqueue of pc=0x1000, inst=0x00000013 with out_ready=0 -> after one edge out_valid=1, out_pc=0x1000, count=1; with out_ready=1 next edge -> count=0, out_*=0.
REQ-034 SHALL pass: 4 back-to-back enqueues (pc 0x0,0x4,0x8,0xC) with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; then drain -> outputs 0x0,0x4,0x8,0xC in order.
REQ-035 SHALL pass: steady stream with in_valid=out_ready=1 for 10 cycles from count=2 -> count stays 2, pointers wrap, and PCs emerge in order with a 2-entry lag.
REQ-036 SHALL pass: full queue, out_ready=1 and in_valid=1 in the same cycle -> one dequeue, no enqueue, count=3.
REQ-037 SHALL pass: flush=1 with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle entry is absent.
REQ-038 SHALL pass: reset=0 for one edge with count=2, then release -> count=0, in_ready=1, and the next enqueue appears first at the output.
